// File: rtl/board_ram_arbiter.sv
// rtl/board_ram_arbiter.sv - game/display arbiter for the 32768x3 board RAM, optional wipe engine (BOARD_ARB_CLEAR_EN)
`timescale 1ns/1ps

module board_ram_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        g_req,
    input  logic        g_we,
    input  logic [14:0] g_addr,
    input  logic [2:0]  g_wdata,
    output logic        g_gnt,
    output logic        g_rvalid,
    output logic [2:0]  g_rdata,
    input  logic        d_req,
    input  logic [14:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [2:0]  d_rdata,
    input  logic        clear_req,
    output logic        clear_busy,
    output logic [14:0] ram_addr,
    output logic [2:0]  ram_wdata,
    output logic        ram_wren,
    input  logic [2:0]  ram_q
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic        clearing;
    logic [14:0] clr_addr;

    logic [3:0]  wait_q, wait_d;
    logic        g_win, d_win;
    logic [14:0] addr_q;
    logic [2:0]  wdata_q;
    logic        g_tag_q, d_tag_q;
    logic [2:0]  g_rdata_q, d_rdata_q;

`ifdef BOARD_ARB_CLEAR_EN
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t      state_q;
    logic [14:0] clr_cnt_q;
    logic        clear_busy_q;

    // Wipe FSM: one write per cycle over the whole board, then back to arbitration
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear_req) begin
                        state_q      <= ST_CLEAR;
                        clr_cnt_q    <= '0;
                        clear_busy_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 15'd1;
                    if (clr_cnt_q == 15'h7FFF) begin
                        state_q      <= ST_IDLE;
                        clear_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    clear_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clearing   = (state_q == ST_CLEAR);
    assign clr_addr   = clr_cnt_q;
    assign clear_busy = clear_busy_q;
`else
    logic unused_clear_req;

    assign unused_clear_req = clear_req;
    assign clearing         = 1'b0;
    assign clr_addr         = '0;
    assign clear_busy       = 1'b0;
`endif

    // Grant decision: game has priority unless the display has waited MAX_WAIT cycles
    always_comb begin
        g_win = 1'b0;
        d_win = 1'b0;
        if (resetn && !clearing) begin
            if (d_req && ((wait_q == MAX_WAIT_C) || !g_req)) begin
                d_win = 1'b1;
            end else if (g_req) begin
                g_win = 1'b1;
            end
        end
    end

    // Display starvation counter: counts denied cycles, saturates, clears on grant or idle
    always_comb begin
        wait_d = wait_q;
        if (clearing || !d_req || d_win) begin
            wait_d = '0;
        end else if (wait_q < MAX_WAIT_C) begin
            wait_d = wait_q + 4'd1;
        end
    end

    // RAM port mux: wipe engine, then the winner, otherwise hold the last address/data
    always_comb begin
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        ram_wren  = 1'b0;
        if (clearing) begin
            ram_addr  = clr_addr;
            ram_wdata = 3'b000;
            ram_wren  = 1'b1;
        end else if (g_win) begin
            ram_addr  = g_addr;
            ram_wdata = g_wdata;
            ram_wren  = g_we;
        end else if (d_win) begin
            ram_addr  = d_addr;
        end
    end

    // Starvation counter register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    // Remember the RAM drive for hold cycles and tag granted reads for the return path
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            g_tag_q <= 1'b0;
            d_tag_q <= 1'b0;
        end else begin
            addr_q  <= ram_addr;
            wdata_q <= ram_wdata;
            g_tag_q <= g_win && !g_we;
            d_tag_q <= d_win;
        end
    end

    // Capture returned read data so each requester's rdata holds between pulses
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            g_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (g_tag_q) begin
                g_rdata_q <= ram_q;
            end
            if (d_tag_q) begin
                d_rdata_q <= ram_q;
            end
        end
    end

    assign g_gnt    = g_win;
    assign d_gnt    = d_win;
    assign g_rvalid = g_tag_q;
    assign d_rvalid = d_tag_q;
    assign g_rdata  = g_tag_q ? ram_q : g_rdata_q;
    assign d_rdata  = d_tag_q ? ram_q : d_rdata_q;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb/tb_board_ram_arbiter.sv - self-checking bench for board_ram_arbiter with a board RAM model
`timescale 1ns/1ps

module tb_board_ram_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        resetn   = 1'b0;
    logic        g_req = 1'b0, g_we = 1'b0;
    logic [14:0] g_addr = '0;
    logic [2:0]  g_wdata = '0;
    logic        g_gnt, g_rvalid;
    logic [2:0]  g_rdata;
    logic        d_req = 1'b0;
    logic [14:0] d_addr = '0;
    logic        d_gnt, d_rvalid;
    logic [2:0]  d_rdata;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic [14:0] ram_addr;
    logic [2:0]  ram_wdata;
    logic        ram_wren;
    logic [2:0]  ram_q;

    board_ram_arbiter #(.MAX_WAIT(4)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_gnt(g_gnt), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
        .d_req(d_req), .d_addr(d_addr),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Board RAM: synchronous read, one cycle latency
    logic [2:0] ram [0:32767];
    always @(posedge CLOCK_50) begin
        if (ram_wren) ram[ram_addr] <= ram_wdata;
        ram_q <= ram[ram_addr];
    end

    logic [2:0] shadow [0:32767];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       game;
        logic [2:0] data;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       nm;
        logic        gr, gw;
        logic [14:0] ga;
        logic [2:0]  gd;
        logic        dr;
        logic [14:0] da;
        logic        cr;
        logic        eg, ed;
        logic [14:0] ea;
        logic        ew;
        logic [2:0]  ewd;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic gr, input logic gw,
                                input logic [14:0] ga, input logic [2:0] gd,
                                input logic dr, input logic [14:0] da,
                                input logic eg, input logic ed, input logic [14:0] ea,
                                input logic ew, input logic [2:0] ewd);
        vec_t v;
        v.nm = nm; v.gr = gr; v.gw = gw; v.ga = ga; v.gd = gd;
        v.dr = dr; v.da = da; v.cr = 1'b0;
        v.eg = eg; v.ed = ed; v.ea = ea; v.ew = ew; v.ewd = ewd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        g_req = v.gr; g_we = v.gw; g_addr = v.ga; g_wdata = v.gd;
        d_req = v.dr; d_addr = v.da; clear_req = v.cr;
    endtask

    task automatic sb_check(input string nm);
        sb_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({nm, " g_rvalid"}, 32'(g_rvalid), 32'(e.game));
            chk({nm, " d_rvalid"}, 32'(d_rvalid), 32'(!e.game));
            if (e.game) chk({nm, " g_rdata"}, 32'(g_rdata), 32'(e.data));
            else        chk({nm, " d_rdata"}, 32'(d_rdata), 32'(e.data));
        end else begin
            chk({nm, " no rvalid"}, 32'({g_rvalid, d_rvalid}), 32'd0);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge CLOCK_50);
        drive(v);
        #1;
        sb_check(v.nm);
        chk({v.nm, " g_gnt"}, 32'(g_gnt), 32'(v.eg));
        chk({v.nm, " d_gnt"}, 32'(d_gnt), 32'(v.ed));
        chk({v.nm, " ram_addr"}, 32'(ram_addr), 32'(v.ea));
        chk({v.nm, " ram_wren"}, 32'(ram_wren), 32'(v.ew));
        if (!v.ed) chk({v.nm, " ram_wdata"}, 32'(ram_wdata), 32'(v.ewd));
        if (v.eg && !v.gw) sb_q.push_back('{1'b1, shadow[v.ga]});
        if (v.eg && v.gw)  shadow[v.ga] = v.gd;
        if (v.ed)          sb_q.push_back('{1'b0, shadow[v.da]});
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " flags"}, 32'({g_gnt, d_gnt, g_rvalid, d_rvalid, ram_wren, clear_busy}), 32'd0);
        chk({nm, " rdata"}, 32'({g_rdata, d_rdata}), 32'd0);
        chk({nm, " ram_addr"}, 32'(ram_addr), 32'd0);
        chk({nm, " ram_wdata"}, 32'(ram_wdata), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        vec_t v;
        int   n;
        int   bad_gnt, bad_wr, bad_addr, bad_rv;

        // Reset holds every output low even with active requests
        g_req = 1'b1; g_we = 1'b1; g_addr = 15'h7FFF; g_wdata = 3'b111;
        d_req = 1'b1; d_addr = 15'h1111; clear_req = 1'b1;
        #12;
        chk_all_zero("reset");
        idle = mk("idle", 1'b0, 1'b0, 15'h0, 3'd0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0, 1'b0, 3'd0);
        @(negedge CLOCK_50);
        drive(idle);
        resetn = 1'b1;

        tbl.push_back(mk("idle0",   1'b0, 1'b0, 15'h0000, 3'd0, 1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 1'b0, 3'd0));
        tbl.push_back(mk("gwr0",    1'b1, 1'b1, 15'h0000, 3'd5, 1'b0, 15'h0000, 1'b1, 1'b0, 15'h0000, 1'b1, 3'd5));
        tbl.push_back(mk("gwr1",    1'b1, 1'b1, 15'h0001, 3'd2, 1'b0, 15'h0000, 1'b1, 1'b0, 15'h0001, 1'b1, 3'd2));
        tbl.push_back(mk("gwr2",    1'b1, 1'b1, 15'h0002, 3'd7, 1'b0, 15'h0000, 1'b1, 1'b0, 15'h0002, 1'b1, 3'd7));
        tbl.push_back(mk("gwr3",    1'b1, 1'b1, 15'h0003, 3'd4, 1'b0, 15'h0000, 1'b1, 1'b0, 15'h0003, 1'b1, 3'd4));
        tbl.push_back(mk("gwr281",  1'b1, 1'b1, 15'h0281, 3'd1, 1'b0, 15'h0000, 1'b1, 1'b0, 15'h0281, 1'b1, 3'd1));
        tbl.push_back(mk("grd281",  1'b1, 1'b0, 15'h0281, 3'd0, 1'b0, 15'h0000, 1'b1, 1'b0, 15'h0281, 1'b0, 3'd0));
        tbl.push_back(mk("idle1",   1'b0, 1'b0, 15'h0000, 3'd0, 1'b0, 15'h0000, 1'b0, 1'b0, 15'h0281, 1'b0, 3'd0));
        tbl.push_back(mk("drd0",    1'b0, 1'b0, 15'h0000, 3'd0, 1'b1, 15'h0000, 1'b0, 1'b1, 15'h0000, 1'b0, 3'd0));
        tbl.push_back(mk("drd1",    1'b0, 1'b0, 15'h0000, 3'd0, 1'b1, 15'h0001, 1'b0, 1'b1, 15'h0001, 1'b0, 3'd0));
        tbl.push_back(mk("drd2",    1'b0, 1'b0, 15'h0000, 3'd0, 1'b1, 15'h0002, 1'b0, 1'b1, 15'h0002, 1'b0, 3'd0));
        tbl.push_back(mk("drd3",    1'b0, 1'b0, 15'h0000, 3'd0, 1'b1, 15'h0003, 1'b0, 1'b1, 15'h0003, 1'b0, 3'd0));
        tbl.push_back(mk("idle2",   1'b0, 1'b0, 15'h0000, 3'd0, 1'b0, 15'h0000, 1'b0, 1'b0, 15'h0003, 1'b0, 3'd0));
        tbl.push_back(mk("gwr_dw",  1'b1, 1'b1, 15'h1234, 3'd6, 1'b1, 15'h1234, 1'b1, 1'b0, 15'h1234, 1'b1, 3'd6));
        tbl.push_back(mk("drd1234", 1'b0, 1'b0, 15'h0000, 3'd0, 1'b1, 15'h1234, 1'b0, 1'b1, 15'h1234, 1'b0, 3'd6));
        tbl.push_back(mk("idle3",   1'b0, 1'b0, 15'h0000, 3'd0, 1'b0, 15'h0000, 1'b0, 1'b0, 15'h1234, 1'b0, 3'd6));
        foreach (tbl[i]) step(tbl[i]);

        // Both requesters held: display forced through every fifth cycle
        for (int i = 0; i < 12; i++) begin
            logic ed;
            ed = ((i % 5) == 4);
            step(mk("starve", 1'b1, 1'b0, 15'h0281, 3'd0, 1'b1, 15'h0002,
                    !ed, ed, ed ? 15'h0002 : 15'h0281, 1'b0, 3'd0));
        end
        step(mk("idle4", 1'b0, 1'b0, 15'h0, 3'd0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0281, 1'b0, 3'd0));

        // Dropping d_req for one cycle restarts the wait count
        for (int i = 0; i < 9; i++) begin
            logic dr, ed;
            dr = (i != 3);
            ed = (i == 8);
            step(mk("waitclr", 1'b1, 1'b0, 15'h0281, 3'd0, dr, 15'h0002,
                    !ed, ed, ed ? 15'h0002 : 15'h0281, 1'b0, 3'd0));
        end
        step(mk("idle5", 1'b0, 1'b0, 15'h0, 3'd0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0002, 1'b0, 3'd0));
        step(mk("idle6", 1'b0, 1'b0, 15'h0, 3'd0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0002, 1'b0, 3'd0));
        chk("g_rdata hold", 32'(g_rdata), 32'd1);
        chk("d_rdata hold", 32'(d_rdata), 32'd7);

`ifdef BOARD_ARB_CLEAR_EN
        step(mk("gwr7fff", 1'b1, 1'b1, 15'h7FFF, 3'd7, 1'b0, 15'h0, 1'b1, 1'b0, 15'h7FFF, 1'b1, 3'd7));
        v = mk("clrpulse", 1'b0, 1'b0, 15'h0, 3'd0, 1'b1, 15'h0003, 1'b0, 1'b1, 15'h0003, 1'b0, 3'd0);
        v.cr = 1'b1;
        step(v);
        chk("busy before edge", 32'(clear_busy), 32'd0);

        bad_gnt = 0; bad_wr = 0; bad_addr = 0; bad_rv = 0;
        for (n = 0; n < 40000; n++) begin
            @(negedge CLOCK_50);
            g_req = 1'b1; g_we = 1'b0; g_addr = 15'h0005;
            d_req = 1'b1; d_addr = 15'h0005;
            clear_req = (n == 10);
            #1;
            if (!clear_busy) break;
            if (n == 0) sb_check("clr first");
            else if (g_rvalid || d_rvalid) bad_rv++;
            if (g_gnt || d_gnt) bad_gnt++;
            if (!ram_wren || ram_wdata != 3'd0) bad_wr++;
            if (ram_addr != 15'(n)) bad_addr++;
        end
        chk("clear length", 32'(n), 32'd32768);
        chk("clear grants", 32'(bad_gnt), 32'd0);
        chk("clear writes", 32'(bad_wr), 32'd0);
        chk("clear addr seq", 32'(bad_addr), 32'd0);
        chk("clear rvalid", 32'(bad_rv), 32'd0);
        for (int a = 0; a < 32768; a++) shadow[a] = 3'd0;
        chk("post clear g_gnt", 32'(g_gnt), 32'd1);
        chk("post clear addr", 32'(ram_addr), 32'h5);
        sb_q.push_back('{1'b1, shadow[5]});
        step(mk("d7fff", 1'b0, 1'b0, 15'h0, 3'd0, 1'b1, 15'h7FFF, 1'b0, 1'b1, 15'h7FFF, 1'b0, 3'd0));
        step(mk("idle7", 1'b0, 1'b0, 15'h0, 3'd0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h7FFF, 1'b0, 3'd0));

        // Reset in the middle of a wipe abandons it
        step(mk("gwr200", 1'b1, 1'b1, 15'd200, 3'd5, 1'b0, 15'h0, 1'b1, 1'b0, 15'd200, 1'b1, 3'd5));
        v = mk("clrpulse2", 1'b0, 1'b0, 15'h0, 3'd0, 1'b0, 15'h0, 1'b0, 1'b0, 15'd200, 1'b0, 3'd5);
        v.cr = 1'b1;
        step(v);
        for (n = 0; n < 300; n++) begin
            @(negedge CLOCK_50);
            drive(idle);
            #1;
            if (ram_addr == 15'd100) break;
        end
        chk("wipe reaches 100", 32'(n), 32'd100);
        chk("busy at 100", 32'(clear_busy), 32'd1);
        #1;
        resetn = 1'b0;
        g_req = 1'b1; g_we = 1'b1; d_req = 1'b1;
        #1;
        chk_all_zero("mid-wipe reset");
        sb_q.delete();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk_all_zero("held reset");
        drive(idle);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(mk("after rst", 1'b0, 1'b0, 15'h0, 3'd0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0, 1'b0, 3'd0));
            chk("busy after rst", 32'(clear_busy), 32'd0);
        end
        step(mk("d200", 1'b0, 1'b0, 15'h0, 3'd0, 1'b1, 15'd200, 1'b0, 1'b1, 15'd200, 1'b0, 3'd0));
        step(mk("idle8", 1'b0, 1'b0, 15'h0, 3'd0, 1'b0, 15'h0, 1'b0, 1'b0, 15'd200, 1'b0, 3'd0));
`else
        // Without the wipe engine a clear request changes nothing
        v = mk("clr_ign", 1'b1, 1'b0, 15'h0281, 3'd0, 1'b0, 15'h0, 1'b1, 1'b0, 15'h0281, 1'b0, 3'd0);
        v.cr = 1'b1;
        step(v);
        chk("busy same cycle", 32'(clear_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(mk("clr_ign_idle", 1'b0, 1'b0, 15'h0, 3'd0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0281, 1'b0, 3'd0));
            chk("busy stays 0", 32'(clear_busy), 32'd0);
        end

        // Asynchronous reset mid-cycle clears outputs at once
        #2;
        resetn = 1'b0;
        g_req = 1'b1; g_we = 1'b1; d_req = 1'b1;
        #1;
        chk_all_zero("async reset");
        sb_q.delete();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk_all_zero("held reset");
        drive(idle);
        resetn = 1'b1;
        step(mk("first grant", 1'b1, 1'b0, 15'h0281, 3'd0, 1'b0, 15'h0, 1'b1, 1'b0, 15'h0281, 1'b0, 3'd0));
        step(mk("idle9", 1'b0, 1'b0, 15'h0, 3'd0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0281, 1'b0, 3'd0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
